// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump controller.
// REGDUMP_CHECKSUM_EN adds the SEND_SUM state used by the optional checksum beat.
package regdump_pkg;

    localparam int REGDUMP_NUM_PAIRS = 16;
    localparam int REGDUMP_ADDR_W    = 5;
    localparam int REGDUMP_DATA_W    = 32;
    localparam int REGDUMP_PAIR_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SEND_LO,
        ST_SEND_HI,
        ST_DONE
`ifdef REGDUMP_CHECKSUM_EN
        ,
        ST_SEND_SUM
`endif
    } regdump_state_e;

    // Register number of one half of a pair: even half is 2p, odd half 2p+1.
    function automatic logic [REGDUMP_ADDR_W-1:0] pair_reg(
        input logic [REGDUMP_PAIR_W-1:0] pair,
        input logic                      odd
    );
        return {pair, odd};
    endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Bus bundle of the dump controller: register-file read port, start/abort
// control and the valid/ready beat stream towards the consumer.
interface regfile_dump_if;
    import regdump_pkg::*;

    logic                      in_start;
    logic                      in_abort;
    logic                      out_rs_rena;
    logic                      out_rt_rena;
    logic [REGDUMP_ADDR_W-1:0] out_rs_addr;
    logic [REGDUMP_ADDR_W-1:0] out_rt_addr;
    logic [REGDUMP_DATA_W-1:0] in_rs_data;
    logic [REGDUMP_DATA_W-1:0] in_rt_data;
    logic                      out_valid;
    logic                      in_ready;
    logic [REGDUMP_DATA_W-1:0] out_data;
    logic [REGDUMP_ADDR_W-1:0] out_index;
    logic                      out_last;
    logic                      out_busy;
    logic                      out_done;

    modport master (
        input  in_start, in_abort, in_rs_data, in_rt_data, in_ready,
        output out_rs_rena, out_rt_rena, out_rs_addr, out_rt_addr,
        output out_valid, out_data, out_index, out_last, out_busy, out_done
    );

    modport slave (
        output in_start, in_abort, in_rs_data, in_rt_data, in_ready,
        input  out_rs_rena, out_rt_rena, out_rs_addr, out_rt_addr,
        input  out_valid, out_data, out_index, out_last, out_busy, out_done
    );

endinterface

// File: rtl/regdump_xor_acc.sv
// Running XOR of accepted dump beats; cleared when a new pass starts.
module regdump_xor_acc
    import regdump_pkg::*;
(
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic                      clear,
    input  logic                      en,
    input  logic [REGDUMP_DATA_W-1:0] data,
    output logic [REGDUMP_DATA_W-1:0] sum
);

    logic [REGDUMP_DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = '0;
        end else if (en) begin
            sum_d = sum_q ^ data;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/regfile_dump.sv
// Dumps register pairs FIRST_PAIR..LAST_PAIR as a valid/ready beat stream.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat after the last pair.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for in_start
// ISSUE     | both read enables high for one cycle, data captured
// SEND_LO   | presenting even register 2p
// SEND_HI   | presenting odd register 2p+1
// SEND_SUM  | presenting the XOR checksum (checksum build only)
// DONE      | one-cycle completion pulse
module regfile_dump
    import regdump_pkg::*;
#(
    parameter int FIRST_PAIR = 0,
    parameter int LAST_PAIR  = 15
) (
    input  logic           in_clk,
    input  logic           in_rst,
    regfile_dump_if.master bus
);

    if (FIRST_PAIR < 0 || FIRST_PAIR > LAST_PAIR || LAST_PAIR > REGDUMP_NUM_PAIRS - 1)
    begin : g_bad_pair_range
        $error("regfile_dump: need 0 <= FIRST_PAIR <= LAST_PAIR <= 15");
    end

    localparam logic [REGDUMP_PAIR_W-1:0] FIRST_P = REGDUMP_PAIR_W'(FIRST_PAIR);
    localparam logic [REGDUMP_PAIR_W-1:0] LAST_P  = REGDUMP_PAIR_W'(LAST_PAIR);

    regdump_state_e            state_q, state_d;
    logic [REGDUMP_PAIR_W-1:0] pair_q, pair_d;
    logic [REGDUMP_DATA_W-1:0] lo_q, lo_d;
    logic [REGDUMP_DATA_W-1:0] hi_q, hi_d;

    logic                      rena;
    logic [REGDUMP_ADDR_W-1:0] rs_addr, rt_addr;
    logic                      valid, last, busy, done;
    logic [REGDUMP_DATA_W-1:0] data;
    logic [REGDUMP_ADDR_W-1:0] index;
    logic                      start_pass;
    logic                      beat_acc;

`ifdef REGDUMP_CHECKSUM_EN
    logic [REGDUMP_DATA_W-1:0] sum;

    regdump_xor_acc u_xor_acc (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .clear  (start_pass),
        .en     (beat_acc),
        .data   (data),
        .sum    (sum)
    );
`endif

    always_comb begin
        state_d    = state_q;
        pair_d     = pair_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        rena       = 1'b0;
        rs_addr    = '0;
        rt_addr    = '0;
        valid      = 1'b0;
        data       = '0;
        index      = '0;
        last       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        start_pass = 1'b0;
        beat_acc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_start) begin
                    start_pass = 1'b1;
                    pair_d     = FIRST_P;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy    = 1'b1;
                rena    = 1'b1;
                rs_addr = pair_reg(pair_q, 1'b0);
                rt_addr = pair_reg(pair_q, 1'b1);
                lo_d    = bus.in_rs_data;
                hi_d    = bus.in_rt_data;
                state_d = ST_SEND_LO;
            end
            ST_SEND_LO: begin
                busy     = 1'b1;
                valid    = 1'b1;
                data     = lo_q;
                index    = pair_reg(pair_q, 1'b0);
                beat_acc = bus.in_ready && !bus.in_abort;
                if (bus.in_ready) begin
                    state_d = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                busy     = 1'b1;
                valid    = 1'b1;
                data     = hi_q;
                index    = pair_reg(pair_q, 1'b1);
                beat_acc = bus.in_ready && !bus.in_abort;
`ifndef REGDUMP_CHECKSUM_EN
                last     = (pair_q == LAST_P);
`endif
                if (bus.in_ready) begin
                    if (pair_q != LAST_P) begin
                        pair_d  = pair_q + 4'd1;
                        state_d = ST_ISSUE;
                    end else begin
`ifdef REGDUMP_CHECKSUM_EN
                        state_d = ST_SEND_SUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_SEND_SUM: begin
                busy  = 1'b1;
                valid = 1'b1;
                data  = sum;
                last  = 1'b1;
                if (bus.in_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over a simultaneous accept and never produces a done pulse.
        if (bus.in_abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
            pair_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign bus.out_rs_rena = rena;
    assign bus.out_rt_rena = rena;
    assign bus.out_rs_addr = rs_addr;
    assign bus.out_rt_addr = rt_addr;
    assign bus.out_valid   = valid;
    assign bus.out_data    = data;
    assign bus.out_index   = index;
    assign bus.out_last    = last;
    assign bus.out_busy    = busy;
    assign bus.out_done    = done;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a default-range DUT and a single-pair
// DUT (FIRST_PAIR=LAST_PAIR=3) driven from one beat collector against a queue model.
module tb_regfile_dump;
    import regdump_pkg::*;

`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic in_clk = 1'b0;
    logic in_rst = 1'b1;
    always #5 in_clk = ~in_clk;

    regfile_dump_if bus0 ();
    regfile_dump_if bus1 ();

    regfile_dump u_dut (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus0)
    );

    regfile_dump #(.FIRST_PAIR(3), .LAST_PAIR(3)) u_dut3 (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus1)
    );

    logic        sel   = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] regs [32];
    int          reads = 0;

    assign bus0.in_start = start & ~sel;
    assign bus1.in_start = start & sel;
    assign bus0.in_abort = abort & ~sel;
    assign bus1.in_abort = abort & sel;
    assign bus0.in_ready = ready;
    assign bus1.in_ready = ready;

    // Register-file model: read data changes on the falling edge while enabled.
    always @(negedge in_clk) begin
        if (bus0.out_rs_rena) bus0.in_rs_data <= regs[bus0.out_rs_addr];
        if (bus0.out_rt_rena) bus0.in_rt_data <= regs[bus0.out_rt_addr];
        if (bus1.out_rs_rena) bus1.in_rs_data <= regs[bus1.out_rs_addr];
        if (bus1.out_rt_rena) bus1.in_rt_data <= regs[bus1.out_rt_addr];
        if (bus0.out_rs_rena || bus1.out_rs_rena) reads <= reads + 1;
    end

    logic        o_valid, o_last, o_busy, o_done, o_rs_rena, o_rt_rena;
    logic [31:0] o_data;
    logic [4:0]  o_index, o_rs_addr, o_rt_addr;
    assign o_valid   = sel ? bus1.out_valid   : bus0.out_valid;
    assign o_last    = sel ? bus1.out_last    : bus0.out_last;
    assign o_busy    = sel ? bus1.out_busy    : bus0.out_busy;
    assign o_done    = sel ? bus1.out_done    : bus0.out_done;
    assign o_rs_rena = sel ? bus1.out_rs_rena : bus0.out_rs_rena;
    assign o_rt_rena = sel ? bus1.out_rt_rena : bus0.out_rt_rena;
    assign o_data    = sel ? bus1.out_data    : bus0.out_data;
    assign o_index   = sel ? bus1.out_index   : bus0.out_index;
    assign o_rs_addr = sel ? bus1.out_rs_addr : bus0.out_rs_addr;
    assign o_rt_addr = sel ? bus1.out_rt_addr : bus0.out_rt_addr;

    logic [52:0] all_out0;
    assign all_out0 = {bus0.out_rs_rena, bus0.out_rt_rena, bus0.out_rs_addr, bus0.out_rt_addr,
                       bus0.out_valid, bus0.out_data, bus0.out_index, bus0.out_last,
                       bus0.out_busy, bus0.out_done};

    int tests = 0;
    int fails = 0;

    logic [31:0] beat_data [$];
    logic [4:0]  beat_idx  [$];
    logic        beat_last [$];
    logic [31:0] exp_data  [$];
    logic [4:0]  exp_idx   [$];
    logic        exp_last  [$];

    int done_cyc, done_cnt, stab_err, rena_err, addr_err, pass_reads;
    bit abort_ok, timed_out;

    // Expected stream: pairs in order, each even then odd register, then optional checksum.
    function automatic void build_expected(input int first, input int last_p);
        logic [31:0] sum = '0;
        exp_data.delete(); exp_idx.delete(); exp_last.delete();
        for (int p = first; p <= last_p; p++) begin
            exp_data.push_back(regs[2*p]);
            exp_idx.push_back(5'(2*p));
            exp_last.push_back(1'b0);
            exp_data.push_back(regs[2*p+1]);
            exp_idx.push_back(5'(2*p+1));
            exp_last.push_back((p == last_p) && !CSUM);
            sum = sum ^ regs[2*p] ^ regs[2*p+1];
        end
        if (CSUM) begin
            exp_data.push_back(sum);
            exp_idx.push_back(5'd0);
            exp_last.push_back(1'b1);
        end
    endfunction

    function automatic int first_beat_diff(input int n);
        for (int i = 0; i < n; i++) begin
            if (i >= beat_data.size() || i >= exp_data.size()) return i;
            if (beat_data[i] !== exp_data[i] || beat_idx[i] !== exp_idx[i] ||
                beat_last[i] !== exp_last[i]) return i;
        end
        return -1;
    endfunction

    function automatic void randomize_regs();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
    endfunction

    // Starts a pass on the selected DUT and records every accepted beat.
    task automatic run_pass(input bit rand_ready, input int stall_index, input int stall_cycles,
                            input int abort_index, input bit hold_start, input int max_cycles);
        int          cyc        = 0;
        int          stall_left = stall_cycles;
        int          abort_cyc  = -1;
        int          reads0;
        bit          prev_valid = 1'b0;
        bit          prev_ready = 1'b0;
        logic [31:0] prev_data  = '0;
        logic [4:0]  prev_index = '0;
        logic        prev_last  = 1'b0;
        beat_data.delete(); beat_idx.delete(); beat_last.delete();
        done_cyc = -1; done_cnt = 0; stab_err = 0; rena_err = 0; addr_err = 0;
        abort_ok = 1'b1; timed_out = 1'b0;
        reads0 = reads;
        start = 1'b1;
        @(posedge in_clk); #1;
        start = 1'b0;
        cyc = 1;
        while (1) begin
            ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (o_valid && int'(o_index) == stall_index && stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end
            abort = 1'b0;
            if (abort_cyc < 0 && abort_index >= 0 && o_valid && int'(o_index) == abort_index) begin
                abort = 1'b1;
                ready = 1'b1;
                abort_cyc = cyc;
            end
            if (abort_cyc >= 0 && cyc == abort_cyc + 1 && (o_valid || o_busy)) abort_ok = 1'b0;
            start = hold_start && o_busy;
            if (prev_valid && !prev_ready) begin
                if (!o_valid) stab_err++;
                else if (o_data !== prev_data || o_index !== prev_index || o_last !== prev_last)
                    stab_err++;
            end
            if ((o_rs_rena || o_rt_rena) && o_valid) rena_err++;
            if (o_rs_rena !== o_rt_rena) rena_err++;
            if (o_rs_rena && (o_rs_addr[0] !== 1'b0 || o_rt_addr !== 5'(o_rs_addr + 5'd1))) addr_err++;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (o_valid && ready && !abort) begin
                beat_data.push_back(o_data);
                beat_idx.push_back(o_index);
                beat_last.push_back(o_last);
            end
            prev_valid = o_valid;
            prev_ready = ready;
            prev_data  = o_data;
            prev_index = o_index;
            prev_last  = o_last;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            if (abort_cyc >= 0 && cyc >= abort_cyc + 4) break;
            if (cyc >= max_cycles) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge in_clk); #1;
            cyc++;
        end
        abort = 1'b0; ready = 1'b0; start = 1'b0;
        pass_reads = reads - reads0;
    endtask

    task automatic test_reset();
        start = 1'b1;
        @(posedge in_clk); #1;
        tests++;
        if (all_out0 !== '0 || bus1.out_valid !== 1'b0 || bus1.out_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", all_out0);
        end
        start = 1'b0;
        in_rst = 1'b0;
        repeat (2) @(posedge in_clk);
        #1;
        tests++;
        if (all_out0 !== '0) begin
            fails++;
            $display("FAIL idle_outputs: got %h expected 0", all_out0);
        end
    endtask

    task automatic test_full_pass();
        int d;
        int exp_done;
        randomize_regs();
        regs[2] = 32'h11;
        regs[3] = 32'h22;
        sel = 1'b0;
        build_expected(0, 15);
        exp_done = 49 + (CSUM ? 1 : 0);
        run_pass(1'b0, -1, 0, -1, 1'b0, 200);
        tests++;
        if (timed_out || beat_data.size() != exp_data.size()) begin
            fails++;
            $display("FAIL full_count: got %0d beats expected %0d", beat_data.size(), exp_data.size());
        end
        d = first_beat_diff(exp_data.size());
        tests++;
        if (d != -1) begin
            fails++;
            $display("FAIL full_beats: first difference at beat %0d of %0d", d, exp_data.size());
        end
        tests++;
        if (beat_data.size() < 4 || beat_data[2] !== 32'h11 || beat_data[3] !== 32'h22) begin
            fails++;
            $display("FAIL r2_r3: got beats %0d expected 0x11/0x22 at 2/3", beat_data.size());
        end
        tests++;
        if (done_cyc != exp_done || done_cnt != 1) begin
            fails++;
            $display("FAIL full_done: got cycle %0d count %0d expected cycle %0d count 1",
                     done_cyc, done_cnt, exp_done);
        end
        tests++;
        if (pass_reads != 16 || rena_err != 0 || addr_err != 0) begin
            fails++;
            $display("FAIL full_reads: got reads %0d rena_err %0d addr_err %0d expected 16/0/0",
                     pass_reads, rena_err, addr_err);
        end
    endtask

    task automatic test_stall();
        int d;
        int exp_done;
        randomize_regs();
        sel = 1'b0;
        build_expected(0, 15);
        exp_done = 49 + 5 + (CSUM ? 1 : 0);
        run_pass(1'b0, 7, 5, -1, 1'b0, 200);
        d = first_beat_diff(exp_data.size());
        tests++;
        if (d != -1 || beat_data.size() != exp_data.size()) begin
            fails++;
            $display("FAIL stall_beats: first difference at beat %0d, got %0d beats expected %0d",
                     d, beat_data.size(), exp_data.size());
        end
        tests++;
        if (stab_err != 0 || rena_err != 0 || pass_reads != 16) begin
            fails++;
            $display("FAIL stall_hold: got stab_err %0d rena_err %0d reads %0d expected 0/0/16",
                     stab_err, rena_err, pass_reads);
        end
        tests++;
        if (done_cyc != exp_done) begin
            fails++;
            $display("FAIL stall_done: got cycle %0d expected %0d", done_cyc, exp_done);
        end
    endtask

    task automatic test_random_ready();
        int d;
        for (int r = 0; r < 3; r++) begin
            randomize_regs();
            sel = 1'b0;
            build_expected(0, 15);
            run_pass(1'b1, -1, 0, -1, 1'b0, 600);
            d = first_beat_diff(exp_data.size());
            tests++;
            if (timed_out || d != -1 || beat_data.size() != exp_data.size() ||
                stab_err != 0 || done_cnt != 1) begin
                fails++;
                $display("FAIL random_ready: run %0d diff %0d beats %0d/%0d stab_err %0d done %0d",
                         r, d, beat_data.size(), exp_data.size(), stab_err, done_cnt);
            end
        end
    endtask

    task automatic test_abort();
        int d;
        randomize_regs();
        sel = 1'b0;
        build_expected(0, 15);
        run_pass(1'b0, -1, 0, 9, 1'b0, 200);
        tests++;
        if (!abort_ok || done_cnt != 0) begin
            fails++;
            $display("FAIL abort_idle: got abort_ok %0d done %0d expected 1/0", abort_ok, done_cnt);
        end
        d = first_beat_diff(9);
        tests++;
        if (d != -1 || beat_data.size() != 9) begin
            fails++;
            $display("FAIL abort_beats: got %0d beats diff %0d expected 9 beats", beat_data.size(), d);
        end
        run_pass(1'b0, -1, 0, -1, 1'b0, 200);
        d = first_beat_diff(exp_data.size());
        tests++;
        if (d != -1 || beat_data.size() != exp_data.size() || done_cnt != 1) begin
            fails++;
            $display("FAIL abort_redump: diff %0d got %0d beats expected %0d, done %0d",
                     d, beat_data.size(), exp_data.size(), done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int d;
        randomize_regs();
        sel = 1'b0;
        build_expected(0, 15);
        run_pass(1'b0, -1, 0, -1, 1'b1, 200);
        d = first_beat_diff(exp_data.size());
        tests++;
        if (d != -1 || beat_data.size() != exp_data.size() || done_cnt != 1 || pass_reads != 16) begin
            fails++;
            $display("FAIL start_ignored: diff %0d beats %0d/%0d done %0d reads %0d",
                     d, beat_data.size(), exp_data.size(), done_cnt, pass_reads);
        end
    endtask

    task automatic test_single_pair();
        int d;
        int exp_done;
        randomize_regs();
        sel = 1'b1;
        build_expected(3, 3);
        exp_done = 4 + (CSUM ? 1 : 0);
        run_pass(1'b0, -1, 0, -1, 1'b0, 50);
        d = first_beat_diff(exp_data.size());
        tests++;
        if (d != -1 || beat_data.size() != exp_data.size()) begin
            fails++;
            $display("FAIL single_pair_beats: diff %0d got %0d beats expected %0d",
                     d, beat_data.size(), exp_data.size());
        end
        tests++;
        if (done_cyc != exp_done || pass_reads != 1) begin
            fails++;
            $display("FAIL single_pair_done: got cycle %0d reads %0d expected %0d/1",
                     done_cyc, pass_reads, exp_done);
        end
        sel = 1'b0;
    endtask

    task automatic test_mid_reset();
        int d;
        bit saw_done = 1'b0;
        randomize_regs();
        sel = 1'b0;
        ready = 1'b1;
        start = 1'b1;
        @(posedge in_clk); #1;
        start = 1'b0;
        repeat (20) begin
            @(posedge in_clk); #1;
            if (bus0.out_done) saw_done = 1'b1;
        end
        in_rst = 1'b1;
        #1;
        tests++;
        if (all_out0 !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %h expected 0", all_out0);
        end
        @(posedge in_clk); #1;
        if (bus0.out_done) saw_done = 1'b1;
        in_rst = 1'b0;
        repeat (2) begin
            @(posedge in_clk); #1;
            if (bus0.out_done || bus0.out_busy) saw_done = 1'b1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL mid_reset_discard: got done/busy after reset expected none");
        end
        ready = 1'b0;
        build_expected(0, 15);
        run_pass(1'b0, -1, 0, -1, 1'b0, 200);
        d = first_beat_diff(exp_data.size());
        tests++;
        if (d != -1 || beat_data.size() != exp_data.size() || done_cnt != 1) begin
            fails++;
            $display("FAIL mid_reset_redump: diff %0d got %0d beats expected %0d, done %0d",
                     d, beat_data.size(), exp_data.size(), done_cnt);
        end
    endtask

`ifdef REGDUMP_CHECKSUM_EN
    task automatic test_checksum();
        int n;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i);
        sel = 1'b0;
        build_expected(0, 15);
        run_pass(1'b0, -1, 0, -1, 1'b0, 200);
        n = beat_data.size();
        tests++;
        if (n != 33 || beat_data[n-1] !== 32'h0 || beat_last[n-1] !== 1'b1 || beat_idx[n-1] !== 5'd0) begin
            fails++;
            $display("FAIL checksum_beat: got %0d beats, last data %h expected 33 beats ending 0",
                     n, (n > 0) ? beat_data[n-1] : 32'hx);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_pass();
        test_stall();
        test_random_ready();
        test_abort();
        test_start_ignored();
        test_single_pair();
        test_mid_reset();
`ifdef REGDUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 The block SHALL have parameter FIRST_PAIR, default 0, which is the first register pair index p; pair p covers registers 2p and 2p+1.
REQ-002 The block SHALL have parameter LAST_PAIR, default 15, which is the last pair index; legal only when FIRST_PAIR <= LAST_PAIR <= 15.
REQ-003 in_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 in_rst  input  1  reset, asynchronous, active-high.
REQ-005 in_start  input  1  request one dump pass; sampled only in IDLE.
REQ-006 in_abort  input  1  synchronous abort of the pass in progress.
REQ-007 out_rs_rena, out_rt_rena  output  1 each  read enables to the register file.
REQ-008 out_rs_addr, out_rt_addr  output  5 each  read addresses; rs carries 2p, rt carries 2p+1.
REQ-009 in_rs_data, in_rt_data  input  32 each  register-file read data, updated on the falling edge while the enable is high.
REQ-010 out_valid  output  1  a dump beat is presented.
REQ-011 in_ready  input  1  consumer accepts the beat.
REQ-012 out_data  output  32  beat payload.
REQ-013 out_index  output  5  register number of the beat.
REQ-014 out_last  output  1  final beat of the pass.
REQ-015 out_busy  output  1  a pass is in progress.
REQ-016 out_done  output  1  one-cycle pulse when a pass completes.

Function
REQ-017 The FSM states SHALL be IDLE, ISSUE, SEND_LO, SEND_HI, SEND_SUM and DONE.
REQ-018 IDLE: when in_start=1, load pair counter=FIRST_PAIR and go to ISSUE; out_busy rises in the next cycle.
REQ-019 ISSUE (exactly one cycle): both renas high, addresses driven; at the closing rising edge, capture in_rs_data/in_rt_data into lo/hi buffers and go to SEND_LO.
REQ-020 Renas SHALL be low in every state except ISSUE.
REQ-021 SEND_LO: out_valid=1, out_data=lo, out_index=2p; on out_valid&in_ready go to SEND_HI.
REQ-022 SEND_HI: out_data=hi, out_index=2p+1; on accept, go to ISSUE with p+1 if p<LAST_PAIR, else to SEND_SUM (macro on) or DONE.
REQ-023 While out_valid=1 and in_ready=0, out_data, out_index and out_last SHALL hold stable.
REQ-024 out_valid SHALL never drop without acceptance, except on abort or reset.
REQ-025 out_last=1 only on the final beat: SEND_SUM with the macro defined, or SEND_HI of LAST_PAIR without it.
REQ-026 DONE (one cycle): out_done=1, out_busy=0; next state IDLE.
REQ-027 in_start outside IDLE SHALL be ignored.
REQ-028 in_abort in any non-IDLE state SHALL force IDLE at the next edge, with no out_done, and SHALL drop out_valid even mid-handshake.
REQ-029 in_abort SHALL take priority over a simultaneous accept.
REQ-030 Pair counter is 4 bits; no wrap is possible because LAST_PAIR <= 15 is checked at elaboration.
REQ-031 Best case per pair is 3 cycles; a full default pass is 48 cycles plus DONE.

Reset
REQ-032 in_rst SHALL asynchronously force IDLE and clear the counter, buffers and checksum.
REQ-033 During reset all outputs SHALL be 0.
REQ-034 Reset mid-pass SHALL discard the pass without out_done.

Configuration
REQ-035 With REGDUMP_CHECKSUM_EN defined:
- the block SHALL keep a running 32-bit XOR of every accepted data beat, cleared on pass start;
- SEND_SUM SHALL present it with out_index=0 and out_last=1;
- on accept it SHALL go to DONE.
REQ-036 Without REGDUMP_CHECKSUM_EN, there SHALL be no SEND_SUM state and no accumulator logic.

Structure
REQ-037 Package regdump_pkg SHALL hold the state enum, REGDUMP_NUM_PAIRS=16 and the address width constant 5.
REQ-038 Sub-module regdump_xor_acc SHALL be instantiated only under REGDUMP_CHECKSUM_EN.

Verification
REQ-039 Preload r2=0x11, r3=0x22, with defaults, in_ready=1, start -> 32 beats with indices 0..31 in order, r2/r3 beats carry 0x11/0x22, out_done pulses at cycle 49.
REQ-040 Hold in_ready=0 for 5 cycles on index 7 -> out_data/out_index stable, renas low, no extra register reads.
REQ-041 Abort while in SEND_HI of pair 4 -> IDLE next cycle, out_valid=0, no out_done; a new start re-dumps from index 0.
REQ-042 Macro on, registers preloaded r_i=i -> a 33rd beat of 0x00000000 (XOR of 0..31) with out_last=1.
REQ-043 FIRST_PAIR=3, LAST_PAIR=3 -> exactly beats 6 and 7, out_last on 7 (macro off).
REQ-044 Assert in_rst in mid-pass -> all outputs 0 immediately; start after release produces a complete pass.
